// File: rtl/key_step_pkg.sv
// Shared types and default parameter values for the key step controller.
// FSM encoding plus debounce / auto-repeat timing defaults.
package key_step_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer with a selectable reset value.
// Used for the raw key and the step-mode switch code.
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage resync into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_step_ctrl.sv
// Debounced pushbutton to one-cycle step strobe with captured mode code.
// Optional auto-repeat while held: define KEY_STEP_AUTOREPEAT_EN.
module key_step_ctrl
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       key_n,
    input  logic [1:0] w_in,
    output logic       step,
    output logic [1:0] w_out,
    output logic       held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_bad_param
        $error("key_step_ctrl: illegal timing parameter");
    end

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          key_sync;
    logic          key_s;
    logic [1:0]    w_sync;
    logic          press_step;
    logic          any_step;

    sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_key_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (key_n),
        .q   (key_sync)
    );

    sync2 #(.WIDTH(2), .RST_VAL(2'b00)) u_w_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (w_in),
        .q   (w_sync)
    );

    assign key_s = ~key_sync;
    assign held  = (state == HELD) || (state == RELEASE_WAIT);

    // Debounce FSM: next state, shared counter and press strobe request.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press_step = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_next = HELD;
                    press_step = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_next = HELD;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef KEY_STEP_AUTOREPEAT_EN
    localparam int RCW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RCW-1:0] FIRST_LIM = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] NEXT_LIM  = RCW'(REPEAT_PERIOD - 1);

    logic [RCW-1:0] rcnt;
    logic           rfirst;
    logic [RCW-1:0] rlim;
    logic           rep_step;

    assign rlim     = rfirst ? FIRST_LIM : NEXT_LIM;
    assign rep_step = (state == HELD) && (rcnt == rlim);
    assign any_step = press_step | rep_step;

    // Repeat timer: runs across release bounce, fires only in HELD.
    always_ff @(posedge Clock) begin
        if (Reset || state == IDLE || state == PRESS_WAIT) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
        end else if (rep_step) begin
            rcnt   <= '0;
            rfirst <= 1'b0;
        end else if (rcnt != rlim) begin
            rcnt <= rcnt + RCW'(1);
        end
    end
`else
    assign any_step = press_step;
`endif

    // State register, strobe and mode capture.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            step  <= 1'b0;
            w_out <= 2'b00;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            step  <= any_step;
            if (any_step) begin
                w_out <= w_sync;
            end
        end
    end

endmodule
